// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: carries one instruction slot between MIPS stages,
// with bubble/exception entry, saturating stall/bubble counters and a stuck-stall watchdog.
module pipe_stage_reg #(
  parameter int unsigned          PAYLOAD_W        = 32,
  parameter int unsigned          EXC_W            = 5,
  parameter logic [31:0]          HANDLER_PC       = 32'h0000_4180,
  parameter bit                   KEEP_PC_ON_FLUSH = 1'b1,
  parameter int unsigned          CNT_W            = 16,
  parameter int unsigned          STALL_LIMIT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 req,
  input  logic                 cnt_clr,
  input  logic                 in_valid,
  input  logic [31:0]          in_ins,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_pcplus4,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic                 in_bd,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [31:0]          out_ins,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_pcplus4,
  output logic [EXC_W-1:0]     out_exc,
  output logic                 out_bd,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic                 stall_stuck
);

  logic                 valid_q, valid_d;
  logic [31:0]          ins_q, ins_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          pcplus4_q, pcplus4_d;
  logic [EXC_W-1:0]     exc_q, exc_d;
  logic                 bd_q, bd_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;
  logic                 hold;
  logic                 bubble;

  // A stall only holds when neither exception entry nor a bubble overrides it.
  assign hold   = stall & ~req & ~flush;
  assign bubble = flush & ~req;

  always_comb begin
    valid_d   = valid_q;
    ins_d     = ins_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    exc_d     = exc_q;
    bd_d      = bd_q;
    payload_d = payload_q;
    if (req) begin
      valid_d   = 1'b0;
      ins_d     = '0;
      pc_d      = HANDLER_PC;
      pcplus4_d = '0;
      exc_d     = '0;
      bd_d      = 1'b0;
      payload_d = '0;
    end else if (flush) begin
      valid_d   = 1'b0;
      ins_d     = '0;
      pcplus4_d = '0;
      exc_d     = '0;
      payload_d = '0;
      pc_d      = KEEP_PC_ON_FLUSH ? in_pc : 32'h0;
      bd_d      = KEEP_PC_ON_FLUSH ? in_bd : 1'b0;
    end else if (!stall) begin
      valid_d   = in_valid;
      ins_d     = in_ins;
      pc_d      = in_pc;
      pcplus4_d = in_pcplus4;
      exc_d     = in_exc;
      bd_d      = in_bd;
      payload_d = in_payload;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (hold && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (bubble && !(&bubble_cnt_q))
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      ins_q        <= '0;
      pc_q         <= '0;
      pcplus4_q    <= '0;
      exc_q        <= '0;
      bd_q         <= 1'b0;
      payload_q    <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ins_q        <= ins_d;
      pc_q         <= pc_d;
      pcplus4_q    <= pcplus4_d;
      exc_q        <= exc_d;
      bd_q         <= bd_d;
      payload_q    <= payload_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  generate
    if (STALL_LIMIT > 0) begin : g_watchdog
      localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);
      localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);
      logic [RUN_W-1:0] run_q, run_d;
      logic             stuck_q, stuck_d;

      always_comb begin
        run_d = '0;
        if (hold)
          run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        // Flag follows the run value being written, so it rises on the limit-th hold edge.
        stuck_d = (run_d == RUN_MAX);
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          run_q   <= '0;
          stuck_q <= 1'b0;
        end else begin
          run_q   <= run_d;
          stuck_q <= stuck_d;
        end
      end

      assign stall_stuck = stuck_q;
    end else begin : g_no_watchdog
      assign stall_stuck = 1'b0;
    end
  endgenerate

  assign out_valid   = valid_q;
  assign out_ins     = ins_q;
  assign out_pc      = pc_q;
  assign out_pcplus4 = pcplus4_q;
  assign out_exc     = exc_q;
  assign out_bd      = bd_q;
  assign out_payload = payload_q;
  assign stall_cnt   = stall_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two configurations driven in lockstep and compared
// every cycle against a cycle-level reference model, plus directed scenarios.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, req, cnt_clr;
  logic        in_valid, in_bd;
  logic [31:0] in_ins, in_pc, in_pcplus4, in_payload;
  logic [4:0]  in_exc;

  logic        a_valid, a_bd, a_stuck;
  logic [31:0] a_ins, a_pc, a_pcp4, a_pay;
  logic [4:0]  a_exc;
  logic [2:0]  a_scnt, a_bcnt;

  logic        b_valid, b_bd, b_stuck;
  logic [31:0] b_ins, b_pc, b_pcp4, b_pay;
  logic [4:0]  b_exc;
  logic [15:0] b_scnt, b_bcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: keep PC on bubble, 3-bit counters, watchdog at 4 holds
  pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b1), .CNT_W(3), .STALL_LIMIT(4)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .in_exc(in_exc), .in_bd(in_bd), .in_payload(in_payload),
    .out_valid(a_valid), .out_ins(a_ins), .out_pc(a_pc), .out_pcplus4(a_pcp4),
    .out_exc(a_exc), .out_bd(a_bd), .out_payload(a_pay),
    .stall_cnt(a_scnt), .bubble_cnt(a_bcnt), .stall_stuck(a_stuck));

  // b: clear PC on bubble, 16-bit counters, watchdog disabled
  pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0), .CNT_W(16), .STALL_LIMIT(0)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
    .in_exc(in_exc), .in_bd(in_bd), .in_payload(in_payload),
    .out_valid(b_valid), .out_ins(b_ins), .out_pc(b_pc), .out_pcplus4(b_pcp4),
    .out_exc(b_exc), .out_bd(b_bd), .out_payload(b_pay),
    .stall_cnt(b_scnt), .bubble_cnt(b_bcnt), .stall_stuck(b_stuck));

  typedef struct {
    logic        valid;
    logic [31:0] ins, pc, pcp4, pay;
    logic [4:0]  exc;
    logic        bd;
    int          scnt, bcnt, run;
    logic        stuck;
  } exp_t;

  exp_t ma, mb;

  function automatic exp_t model_clear();
    exp_t n;
    n.valid = 0; n.ins = 0; n.pc = 0; n.pcp4 = 0; n.pay = 0; n.exc = 0; n.bd = 0;
    n.scnt = 0; n.bcnt = 0; n.run = 0; n.stuck = 0;
    return n;
  endfunction

  // Next state of one configuration from the current inputs, by the priority rules.
  function automatic exp_t model_step(exp_t m, bit keep, int limit, int cmax);
    exp_t n = m;
    bit held = 0;
    if (!reset) return model_clear();
    if (req) begin
      n.valid = 0; n.ins = 0; n.pcp4 = 0; n.exc = 0; n.bd = 0; n.pay = 0;
      n.pc = 32'h0000_4180;
    end else if (flush) begin
      n.valid = 0; n.ins = 0; n.pcp4 = 0; n.exc = 0; n.pay = 0;
      n.pc = keep ? in_pc : 32'h0;
      n.bd = keep ? in_bd : 1'b0;
      n.bcnt = (m.bcnt < cmax) ? m.bcnt + 1 : cmax;
    end else if (stall) begin
      held = 1;
      n.scnt = (m.scnt < cmax) ? m.scnt + 1 : cmax;
    end else begin
      n.valid = in_valid; n.ins = in_ins; n.pc = in_pc; n.pcp4 = in_pcplus4;
      n.exc = in_exc; n.bd = in_bd; n.pay = in_payload;
    end
    if (cnt_clr) begin n.scnt = 0; n.bcnt = 0; end
    if (limit > 0) begin
      n.run   = held ? ((m.run + 1 > limit) ? limit : m.run + 1) : 0;
      n.stuck = (n.run == limit);
    end else begin
      n.stuck = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a.valid", 32'(a_valid), 32'(ma.valid));
    chk("a.ins",   a_ins,  ma.ins);
    chk("a.pc",    a_pc,   ma.pc);
    chk("a.pcp4",  a_pcp4, ma.pcp4);
    chk("a.exc",   32'(a_exc), 32'(ma.exc));
    chk("a.bd",    32'(a_bd),  32'(ma.bd));
    chk("a.pay",   a_pay,  ma.pay);
    chk("a.scnt",  32'(a_scnt), 32'(ma.scnt));
    chk("a.bcnt",  32'(a_bcnt), 32'(ma.bcnt));
    chk("a.stuck", 32'(a_stuck), 32'(ma.stuck));
    chk("b.valid", 32'(b_valid), 32'(mb.valid));
    chk("b.ins",   b_ins,  mb.ins);
    chk("b.pc",    b_pc,   mb.pc);
    chk("b.pcp4",  b_pcp4, mb.pcp4);
    chk("b.exc",   32'(b_exc), 32'(mb.exc));
    chk("b.bd",    32'(b_bd),  32'(mb.bd));
    chk("b.pay",   b_pay,  mb.pay);
    chk("b.scnt",  32'(b_scnt), 32'(mb.scnt));
    chk("b.bcnt",  32'(b_bcnt), 32'(mb.bcnt));
    chk("b.stuck", 32'(b_stuck), 32'(mb.stuck));
  endtask

  // One rising edge: advance the models with the applied inputs, then compare.
  task automatic tick();
    ma = model_step(ma, 1'b1, 4, 7);
    mb = model_step(mb, 1'b0, 0, 65535);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ctl(input logic r, input logic s, input logic f, input logic q, input logic c);
    reset = r; stall = s; flush = f; req = q; cnt_clr = c;
  endtask

  task automatic rand_data();
    in_valid   = 1'($urandom_range(0, 1));
    in_ins     = $urandom();
    in_pc      = $urandom();
    in_pcplus4 = $urandom();
    in_exc     = 5'($urandom_range(0, 31));
    in_bd      = 1'($urandom_range(0, 1));
    in_payload = $urandom();
  endtask

  initial begin
    ma = model_clear();
    mb = model_clear();
    rand_data();
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // reset then load
    in_ins = 32'h2408_0001; in_pc = 32'h3000; in_valid = 1'b1;
    tick(); tick();
    chk("rst.pc", a_pc, 32'h0);
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load.ins", a_ins, 32'h2408_0001);
    chk("load.pc", a_pc, 32'h3000);
    chk("load.valid", 32'(a_valid), 32'h1);

    // stall hold and count
    in_pc = 32'h3004;
    tick();
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
      chk("stall.pc", a_pc, 32'h3004);
    end
    chk("stall.cnt3", 32'(a_scnt), 32'd3);
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("clr.scnt", 32'(b_scnt), 32'd0);

    // flush keeping / clearing PC
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    in_pc = 32'h3010; in_bd = 1'b1; in_exc = 5'd4;
    tick();
    chk("flush.a.pc", a_pc, 32'h3010);
    chk("flush.a.bd", 32'(a_bd), 32'h1);
    chk("flush.a.exc", 32'(a_exc), 32'h0);
    chk("flush.a.bcnt", 32'(a_bcnt), 32'd1);
    chk("flush.b.pc", b_pc, 32'h0);
    chk("flush.b.bd", 32'(b_bd), 32'h0);

    // exception wins over flush and stall
    rand_data();
    ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("req.pc", a_pc, 32'h0000_4180);
    chk("req.bcnt", 32'(a_bcnt), 32'd1);

    // watchdog: 6 holds, release, then reset mid-run
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      rand_data();
      tick();
      chk("wd.stuck", 32'(a_stuck), (i >= 4) ? 32'h1 : 32'h0);
    end
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wd.release", 32'(a_stuck), 32'h0);
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wd.rst", 32'(a_stuck), 32'h0);
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("wd.runcleared", 32'(a_stuck), 32'h0);

    // counter saturation
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat.a", 32'(a_scnt), 32'd7);
    chk("sat.b", 32'(b_scnt), 32'd10);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_data();
      ctl(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 4));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
